serial_rf_tx: RTL and testbench
===============================

SERIAL_RF_TX -- requirements
Module: serial_rf_tx

Interface
REQ-001 Parameter: BIT_TICKS, 3571428, Clk cycles per transmitted bit (14 bit/s at 50 MHz); legal range 2 to 2^32-1.
REQ-002 Parameter: PREAMBLE_BITS, 4, number of alternating preamble bits sent before the start bit; legal range 2 to 8.
REQ-003 Port: Clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port: Rst  input  1  reset; synchronous and active-high.
REQ-005 Port: Data  input  8  byte to transmit; sampled only on acceptance.
REQ-006 Port: Valid  input  1  upstream request to send Data.
REQ-007 Port: Ready  output  1  high when a byte can be accepted; acceptance = Valid && Ready at a rising edge.
REQ-008 Port: SB  output  1  serial bit stream toward the RF modulator and receiver; idle level 1.
REQ-009 Port: Busy  output  1  high while a frame is in progress.
REQ-010 Port: Done  output  1  one-cycle pulse in the last cycle of the stop bit.

Function
REQ-011 The frame SHALL be sent in this order: preamble (1,0,1,0,... for PREAMBLE_BITS bits, starting with 1), start bit 0, Data[0] to Data[7] (LSB first), even-parity bit, stop bit 1.
REQ-012 The even-parity bit SHALL equal the XOR of the 8 latched data bits.
REQ-013 SB SHALL hold each bit for exactly BIT_TICKS Clk cycles; the frame length SHALL be (PREAMBLE_BITS+11)*BIT_TICKS cycles.
REQ-014 The FSM SHALL have the states IDLE, PREAMBLE, START, DATA, PARITY and STOP, and it SHALL move to the next state only at a bit-tick boundary.
REQ-015 In IDLE: Ready=1, Busy=0, SB=1; on acceptance, Data SHALL be latched and the FSM SHALL enter PREAMBLE.
REQ-016 Latency: the first preamble bit SHALL appear on SB in the cycle after the acceptance edge.
REQ-017 Ready SHALL be 0 and Busy SHALL be 1 in every non-IDLE state; Valid and Data SHALL be ignored while Busy.
REQ-018 Done SHALL be 1 only in the final cycle of STOP; in the following cycle the FSM SHALL be in IDLE with Ready=1.
REQ-019 Back-to-back operation: with Valid held high, the next byte SHALL be accepted in the first IDLE cycle, which gives exactly 1 idle cycle (SB=1) between frames.
REQ-020 The bit-tick counter SHALL count from 0 to BIT_TICKS-1 and wrap; it SHALL be cleared on acceptance so that bit timing is aligned to the frame start.
REQ-021 The bit index counters (preamble 0 to PREAMBLE_BITS-1, data 0 to 7) SHALL advance on each tick and SHALL be cleared on state entry.
REQ-022 The counter width SHALL be 32 bits and SHALL never overflow within a bit period.

Reset
REQ-023 When Rst=1 at a rising edge, the next cycle SHALL show: state IDLE, SB=1, Ready=1, Busy=0, Done=0, all counters 0, and the latched data cleared to 0.
REQ-024 Reset mid-frame SHALL abort the frame immediately with no Done pulse; Rst SHALL take priority over a simultaneous Valid.
REQ-025 While Rst=1, Ready SHALL still read 1, but no acceptance SHALL occur.

Structure
REQ-026 A shared package serial_rf_pkg SHALL hold the FSM state encoding, the preamble pattern, the data width (8) and the default BIT_TICKS.
REQ-027 One sub-module baud_tick_gen (parameter BIT_TICKS; ports Clk, Rst, Clear, Tick) SHALL produce the one-cycle bit-tick pulse.
REQ-028 Outputs SB, Ready, Busy and Done SHALL be registered or decoded from registered state only, with no combinational path from Valid.

Verification (BIT_TICKS=4, PREAMBLE_BITS=4)
REQ-029 Accept 0xA5 -> SB = 1,0,1,0 | 0 | 1,0,1,0,0,1,0,1 | 0 | 1, each bit 4 cycles; Done 60 cycles after acceptance; Ready returns the next cycle.
REQ-030 Accept 0x01 -> parity bit = 1; stop = 1; Busy high for exactly 60 cycles.
REQ-031 Valid held high with 0x3C then 0xFF -> two frames separated by exactly 1 idle cycle; 0xFF parity = 0.
REQ-032 Change Data and pulse Valid mid-frame -> no effect on SB; the frame completes with the original byte.
REQ-033 Assert Rst for 1 cycle at cycle 20 of a frame -> next cycle SB=1, Ready=1, Busy=0; no Done pulse; a new byte is then sent correctly.
REQ-034 Rst and Valid high together in IDLE -> no acceptance; SB stays 1.

Source files
------------

// File: rtl/serial_rf_pkg.sv
// Shared definitions for the serial RF transmitter: FSM states, data width,
// default bit period and the preamble pattern.
package serial_rf_pkg;

    localparam int          DATA_W            = 8;
    localparam int unsigned DEFAULT_BIT_TICKS = 32'd3571428;

    // Preamble bits are sent LSB first, so bit 0 (=1) goes out first and the
    // pattern alternates 1,0,1,0,... for up to eight bits.
    localparam logic [7:0]  PREAMBLE_PATTERN  = 8'h55;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREAMBLE = 3'd1,
        START    = 3'd2,
        DATA     = 3'd3,
        PARITY   = 3'd4,
        STOP     = 3'd5
    } state_t;

    // Even parity over one data byte.
    function automatic logic evenParity(input logic [DATA_W-1:0] value);
        return ^value;
    endfunction

endpackage

// File: rtl/serial_rf_tx_baud_tick_gen.sv
// Bit-period timer: counts 0..BIT_TICKS-1 and flags the last cycle of each
// bit period. Clear realigns the period to the start of a new frame.
module baud_tick_gen #(
    parameter int unsigned BIT_TICKS = 32'd3571428
) (
    input  logic Clk,
    input  logic Rst,
    input  logic Clear,
    output logic Tick
);

    localparam logic [31:0] LAST_COUNT = 32'(BIT_TICKS - 32'd1);

    logic [31:0] count_q;

    // Free-running period counter, restarted by reset or a frame start.
    always_ff @(posedge Clk) begin
        if (Rst || Clear) begin
            count_q <= 32'd0;
        end else if (count_q == LAST_COUNT) begin
            count_q <= 32'd0;
        end else begin
            count_q <= count_q + 32'd1;
        end
    end

    assign Tick = (count_q == LAST_COUNT);

endmodule

// File: rtl/serial_rf_tx.sv
// Framed serial transmitter for an RF link: preamble, start bit, eight data
// bits LSB first, even parity and a stop bit, each held for BIT_TICKS cycles.
module serial_rf_tx
    import serial_rf_pkg::*;
#(
    parameter int unsigned BIT_TICKS     = DEFAULT_BIT_TICKS,
    parameter int          PREAMBLE_BITS = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [DATA_W-1:0] Data,
    input  logic              Valid,
    output logic              Ready,
    output logic              SB,
    output logic              Busy,
    output logic              Done
);

    localparam logic [2:0] LAST_PREAMBLE = 3'(PREAMBLE_BITS - 1);
    localparam logic [2:0] LAST_DATA     = 3'(DATA_W - 1);

    state_t            state_q;
    logic [DATA_W-1:0] data_q;
    logic [2:0]        bitIdx_q;
    logic              sb_q;
    logic              tick;
    logic              accept;

    // A byte is taken only from IDLE and never while reset is asserted.
    assign accept = (state_q == IDLE) && Valid && !Rst;

    baud_tick_gen #(
        .BIT_TICKS(BIT_TICKS)
    ) u_tick (
        .Clk  (Clk),
        .Rst  (Rst),
        .Clear(accept),
        .Tick (tick)
    );

    // Frame sequencer: steps through the frame fields on bit-period boundaries
    // and registers the serial bit for the field being entered.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= IDLE;
            data_q   <= '0;
            bitIdx_q <= 3'd0;
            sb_q     <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    sb_q <= 1'b1;
                    if (Valid) begin
                        data_q   <= Data;
                        bitIdx_q <= 3'd0;
                        sb_q     <= PREAMBLE_PATTERN[0];
                        state_q  <= PREAMBLE;
                    end
                end
                PREAMBLE: begin
                    if (tick) begin
                        if (bitIdx_q == LAST_PREAMBLE) begin
                            bitIdx_q <= 3'd0;
                            sb_q     <= 1'b0;
                            state_q  <= START;
                        end else begin
                            bitIdx_q <= bitIdx_q + 3'd1;
                            sb_q     <= PREAMBLE_PATTERN[bitIdx_q + 3'd1];
                        end
                    end
                end
                START: begin
                    if (tick) begin
                        bitIdx_q <= 3'd0;
                        sb_q     <= data_q[0];
                        state_q  <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bitIdx_q == LAST_DATA) begin
                            bitIdx_q <= 3'd0;
                            sb_q     <= evenParity(data_q);
                            state_q  <= PARITY;
                        end else begin
                            bitIdx_q <= bitIdx_q + 3'd1;
                            sb_q     <= data_q[bitIdx_q + 3'd1];
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        sb_q    <= 1'b1;
                        state_q <= STOP;
                    end
                end
                STOP: begin
                    if (tick) begin
                        sb_q    <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    bitIdx_q <= 3'd0;
                    sb_q     <= 1'b1;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign SB    = sb_q;
    assign Ready = (state_q == IDLE);
    assign Busy  = (state_q != IDLE);
    assign Done  = (state_q == STOP) && tick;

endmodule

// File: tb/tb_serial_rf_tx.sv
// Self-checking bench for serial_rf_tx with a short bit period.
module tb_serial_rf_tx;

    localparam int BT    = 4;
    localparam int PRE   = 4;
    localparam int FRAME = (PRE + 11) * BT;

    logic       Clk;
    logic       Rst;
    logic [7:0] Data;
    logic       Valid;
    logic       Ready;
    logic       SB;
    logic       Busy;
    logic       Done;

    int passCount;
    int totalCount;

    serial_rf_tx #(
        .BIT_TICKS    (BT),
        .PREAMBLE_BITS(PRE)
    ) dut (
        .Clk  (Clk),
        .Rst  (Rst),
        .Data (Data),
        .Valid(Valid),
        .Ready(Ready),
        .SB   (SB),
        .Busy (Busy),
        .Done (Done)
    );

    // 10 ns clock
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    typedef struct {
        logic [7:0] data;
        logic       expParity;
        logic       disturb;
    } vec_t;

    // Reference: serial level expected at cycle k (0-based) after acceptance.
    function automatic logic expectedSb(input logic [7:0] d, input int k);
        int b;
        b = k / BT;
        if (b < PRE)      return (b % 2) == 0;
        if (b == PRE)     return 1'b0;
        if (b <= PRE + 8) return d[b - PRE - 1];
        if (b == PRE + 9) return ($countones(d) % 2) == 1;
        return 1'b1;
    endfunction

    task automatic applyStimulus(input logic [7:0] d, input logic v, input logic r);
        Data  = d;
        Valid = v;
        Rst   = r;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        totalCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
        end
    endtask

    task automatic checkIdle(input string name);
        checkOutput({name, " sb"}, {7'd0, SB}, 8'd1);
        checkOutput({name, " rdy/busy/done"}, {5'd0, Ready, Busy, Done}, 8'b100);
    endtask

    // Called in the first cycle of a frame; leaves time in the cycle after Done.
    task automatic checkFrame(input logic [7:0] d, input logic expParity, input logic disturb);
        for (int k = 0; k < FRAME; k++) begin
            checkOutput("frame sb", {7'd0, SB}, {7'd0, expectedSb(d, k)});
            checkOutput("frame rdy/busy/done", {5'd0, Ready, Busy, Done},
                        {5'd0, 1'b0, 1'b1, (k == FRAME - 1)});
            if (k == (PRE + 9) * BT + 1)
                checkOutput("parity bit", {7'd0, SB}, {7'd0, expParity});
            if (k == (PRE + 10) * BT + 2)
                checkOutput("stop bit", {7'd0, SB}, 8'd1);
            if (disturb && k == 8)  applyStimulus(~d, 1'b1, 1'b0);
            if (disturb && k == 30) applyStimulus(8'h00, 1'b0, 1'b0);
            step();
        end
    endtask

    // Present a byte in IDLE, take the acceptance edge, drop Valid.
    task automatic sendByte(input logic [7:0] d, input logic keepValid);
        applyStimulus(d, 1'b1, 1'b0);
        step();
        if (!keepValid) applyStimulus(d, 1'b0, 1'b0);
    endtask

    vec_t vecs[6];

    initial begin
        logic [7:0] rd;
        passCount  = 0;
        totalCount = 0;

        vecs[0] = '{8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h01, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 1'b0, 1'b0};
        vecs[3] = '{8'h80, 1'b1, 1'b0};
        vecs[4] = '{8'h00, 1'b0, 1'b0};
        vecs[5] = '{8'h5B, 1'b1, 1'b1};

        // Reset state, and Ready reads 1 while reset is held.
        applyStimulus(8'h00, 1'b0, 1'b1);
        step();
        checkIdle("reset hold");
        step();
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkIdle("after reset");
        step();

        // Table-driven frames, including a mid-frame Data/Valid disturbance.
        foreach (vecs[i]) begin
            sendByte(vecs[i].data, 1'b0);
            checkFrame(vecs[i].data, vecs[i].expParity, vecs[i].disturb);
            checkIdle("post frame");
            step();
            checkIdle("idle settle");
        end

        // Back-to-back: Valid held, one idle cycle between frames.
        sendByte(8'h3C, 1'b1);
        Data = 8'hFF;
        checkFrame(8'h3C, 1'b0, 1'b0);
        checkIdle("b2b gap");
        step();
        applyStimulus(8'h12, 1'b0, 1'b0);
        checkFrame(8'hFF, 1'b0, 1'b0);
        checkIdle("b2b end");
        step();

        // Reset at cycle 20 of a frame aborts it without Done.
        sendByte(8'hC3, 1'b0);
        for (int k = 0; k < 19; k++) begin
            checkOutput("pre-abort sb", {7'd0, SB}, {7'd0, expectedSb(8'hC3, k)});
            step();
        end
        applyStimulus(8'h00, 1'b0, 1'b1);
        step();
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkIdle("abort");
        for (int k = 0; k < FRAME; k++) begin
            checkOutput("no done after abort", {5'd0, Ready, Busy, Done}, 8'b100);
            step();
        end
        sendByte(8'h96, 1'b0);
        checkFrame(8'h96, 1'b0, 1'b0);
        checkIdle("after abort frame");
        step();

        // Rst and Valid together in IDLE: no acceptance.
        applyStimulus(8'h5A, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            checkIdle("rst+valid");
        end
        applyStimulus(8'h5A, 1'b0, 1'b0);
        step();
        checkIdle("rst+valid release");

        // Randomized bytes with random idle gaps against the reference.
        for (int n = 0; n < 10; n++) begin
            rd = 8'($urandom);
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                step();
                checkIdle("random gap");
            end
            sendByte(rd, 1'b0);
            checkFrame(rd, 1'(($countones(rd) % 2) == 1), 1'b0);
            checkIdle("random end");
        end

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
